cordic_div: RTL and testbench

CORDIC_DIV -- requirements
Module: cordic_div

---
 rtl/cordic_div_if.sv | 24 ++
 rtl/cordic_div.sv | 136 +++++++++++++
 tb/tb_cordic_div.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_div_if.sv
// Operand/result handshake bundle for the linear-vectoring CORDIC divider.
// Master drives operands and result acceptance; slave is the divider.
interface cordic_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] Xin;
    logic [15:0] Yin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Z0;
    logic [15:0] Y0;
    logic        dbz;
    logic        ovf;

    modport master (
        output in_valid, Xin, Yin, out_ready,
        input  in_ready, out_valid, Z0, Y0, dbz, ovf
    );

    modport slave (
        input  in_valid, Xin, Yin, out_ready,
        output in_ready, out_valid, Z0, Y0, dbz, ovf
    );
endinterface

// File: rtl/cordic_div.sv
// Iterative linear-vectoring CORDIC divider: Z0 = Yin / Xin in Q2.13, one iteration per clock.
// Flags divide-by-zero and out-of-range operands; the result is held under backpressure.
module cordic_div #(
    parameter int unsigned ITERS = 14
) (
    input logic        clk,
    input logic        rst_n,
    cordic_div_if.slave div_io
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic signed [17:0] x_q, x_d, y_q, y_d;
    logic signed [15:0] z_q, z_d;
    logic [3:0]         i_q, i_d;
    logic               dbz_q, dbz_d, ovf_q, ovf_d;
    logic [15:0]        z0_q, z0_d, y0_q, y0_d;

    logic               last_iter;
    logic               same_sign;
    logic signed [17:0] x_shr, y_next;
    logic signed [15:0] alpha, z_next;
    logic signed [16:0] xin_s, yin_s;
    logic [16:0]        xin_mag, yin_mag;
    logic               xin_zero, xin_ovf;
    logic [15:0]        y_sat;

    assign last_iter = (i_q == 4'(ITERS - 1));

    // Magnitudes are 17 bits wide so that -32768 maps to +32768.
    always_comb begin
        xin_s    = {div_io.Xin[15], div_io.Xin};
        yin_s    = {div_io.Yin[15], div_io.Yin};
        xin_mag  = xin_s[16] ? unsigned'(-xin_s) : unsigned'(xin_s);
        yin_mag  = yin_s[16] ? unsigned'(-yin_s) : unsigned'(yin_s);
        xin_zero = (div_io.Xin == 16'h0000);
        xin_ovf  = !xin_zero && ({xin_mag, 1'b0} <= {1'b0, yin_mag});
    end

    always_comb begin
        same_sign = (y_q[17] == x_q[17]);
        x_shr     = x_q >>> i_q;
        alpha     = $signed(16'h2000 >> i_q);
        if (same_sign) begin
            y_next = y_q - x_shr;
            z_next = z_q + alpha;
        end else begin
            y_next = y_q + x_shr;
            z_next = z_q - alpha;
        end
        if (y_next > 18'sd32767) begin
            y_sat = 16'h7FFF;
        end else if (y_next < -18'sd32768) begin
            y_sat = 16'h8000;
        end else begin
            y_sat = y_next[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        z0_d    = z0_q;
        y0_d    = y0_q;
        unique case (state_q)
            StIdle: begin
                if (div_io.in_valid) begin
                    state_d = StRun;
                    x_d     = {{2{div_io.Xin[15]}}, div_io.Xin};
                    y_d     = {{2{div_io.Yin[15]}}, div_io.Yin};
                    z_d     = '0;
                    i_d     = '0;
                    dbz_d   = xin_zero;
                    ovf_d   = xin_ovf;
                end
            end
            StRun: begin
                y_d = y_next;
                z_d = z_next;
                i_d = i_q + 4'd1;
                if (last_iter) begin
                    state_d = StDone;
                    // With a zero divisor y never moves, so its sign is still that of Yin.
                    if (dbz_q) begin
                        z0_d = y_q[17] ? 16'h8001 : 16'h7FFF;
                    end else begin
                        z0_d = z_next;
                    end
                    y0_d = y_sat;
                end
            end
            StDone: begin
                if (div_io.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            z0_q    <= '0;
            y0_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            z0_q    <= z0_d;
            y0_q    <= y0_d;
        end
    end

    assign div_io.in_ready  = (state_q == StIdle);
    assign div_io.out_valid = (state_q == StDone);
    assign div_io.Z0        = z0_q;
    assign div_io.Y0        = y0_q;
    assign div_io.dbz       = dbz_q;
    assign div_io.ovf       = ovf_q;
endmodule

// File: tb/tb_cordic_div.sv
// Self-checking bench for cordic_div: vector table, hand-written corner sequences and
// randomized operands compared against an arithmetic quotient model.
module tb_cordic_div;
    localparam int unsigned ITERS = 14;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        int          zlo;
        int          zhi;
        bit          dbz;
        bit          ovf;
        bit          chk_z;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_div_if div_if ();

    cordic_div #(.ITERS(ITERS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .div_io (div_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int sval(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Exact quotient Y/X scaled by 2^13, rounded half away from zero.
    function automatic int ref_quot(input int x, input int y);
        real q;
        q = real'(y) * 8192.0 / real'(x);
        if (q >= 0.0) return $rtoi(q + 0.5);
        return -$rtoi(-q + 0.5);
    endfunction

    function automatic bit ref_ovf(input int x, input int y);
        return (x != 0) && (2 * iabs(x) <= iabs(y));
    endfunction

    // Called at a post-edge sampling point; returns at one too.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int hold,
                          output int lat, output logic [15:0] z0, output logic [15:0] y0,
                          output logic f_dbz, output logic f_ovf);
        int guard;
        guard = 0;
        while (div_if.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        div_if.Xin      = x;
        div_if.Yin      = y;
        div_if.in_valid = 1'b1;
        @(posedge clk); #1;
        div_if.in_valid = 1'b0;
        div_if.Xin      = 16'($urandom);
        div_if.Yin      = 16'($urandom);
        lat = 0;
        while (div_if.out_valid !== 1'b1 && lat < 4 * ITERS) begin
            @(posedge clk); #1;
            lat++;
        end
        z0    = div_if.Z0;
        y0    = div_if.Y0;
        f_dbz = div_if.dbz;
        f_ovf = div_if.ovf;
        repeat (hold) @(posedge clk);
        #1;
        div_if.out_ready = 1'b1;
        @(posedge clk); #1;
        div_if.out_ready = 1'b0;
    endtask

    vec_t        vecs[13];
    int          lat;
    logic [15:0] z0, y0, cz, cy;
    logic        fd, fo, cd, co;
    int          bad;
    int          sx, sy, kk;
    logic [15:0] xv, yv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{x: 16'h2000, y: 16'h1000, zlo: 4094,   zhi: 4098,   dbz: 0, ovf: 0, chk_z: 1};
        vecs[1]  = '{x: 16'hE000, y: 16'h0C00, zlo: -3074,  zhi: -3070,  dbz: 0, ovf: 0, chk_z: 1};
        vecs[2]  = '{x: 16'h0000, y: 16'h1234, zlo: 32767,  zhi: 32767,  dbz: 1, ovf: 0, chk_z: 1};
        vecs[3]  = '{x: 16'h0000, y: 16'hF000, zlo: -32767, zhi: -32767, dbz: 1, ovf: 0, chk_z: 1};
        vecs[4]  = '{x: 16'h1000, y: 16'h2000, zlo: 0,      zhi: 0,      dbz: 0, ovf: 1, chk_z: 0};
        vecs[5]  = '{x: 16'h4000, y: 16'h2000, zlo: 4094,   zhi: 4098,   dbz: 0, ovf: 0, chk_z: 1};
        vecs[6]  = '{x: 16'h0000, y: 16'h0000, zlo: 32767,  zhi: 32767,  dbz: 1, ovf: 0, chk_z: 1};
        vecs[7]  = '{x: 16'h2000, y: 16'hC001, zlo: -16385, zhi: -16381, dbz: 0, ovf: 0, chk_z: 1};
        vecs[8]  = '{x: 16'h6000, y: 16'h6000, zlo: 8190,   zhi: 8194,   dbz: 0, ovf: 0, chk_z: 1};
        vecs[9]  = '{x: 16'h8000, y: 16'h4000, zlo: -4098,  zhi: -4094,  dbz: 0, ovf: 0, chk_z: 1};
        vecs[10] = '{x: 16'h2000, y: 16'hC000, zlo: 0,      zhi: 0,      dbz: 0, ovf: 1, chk_z: 0};
        vecs[11] = '{x: 16'hE000, y: 16'h0000, zlo: -2,     zhi: 2,      dbz: 0, ovf: 0, chk_z: 1};
        vecs[12] = '{x: 16'h2000, y: 16'h3FFF, zlo: 16381,  zhi: 16385,  dbz: 0, ovf: 0, chk_z: 1};

        rst_n            = 1'b0;
        div_if.in_valid  = 1'b0;
        div_if.Xin       = '0;
        div_if.Yin       = '0;
        div_if.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", int'(div_if.out_valid), 0);
        chk("rst_z0", int'(div_if.Z0), 0);
        chk("rst_y0", int'(div_if.Y0), 0);
        chk("rst_dbz", int'(div_if.dbz), 0);
        chk("rst_ovf", int'(div_if.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", int'(div_if.in_ready), 1);

        for (int v = 0; v < 13; v++) begin
            run_op(vecs[v].x, vecs[v].y, v % 3, lat, z0, y0, fd, fo);
            chk($sformatf("vec%0d_latency", v), lat, ITERS);
            chk($sformatf("vec%0d_dbz", v), int'(fd), int'(vecs[v].dbz));
            chk($sformatf("vec%0d_ovf", v), int'(fo), int'(vecs[v].ovf));
            if (vecs[v].chk_z) chk_rng($sformatf("vec%0d_z0", v), sval(z0), vecs[v].zlo, vecs[v].zhi);
            if (vecs[v].dbz) chk($sformatf("vec%0d_y0", v), sval(y0), sval(vecs[v].y));
        end

        // Backpressure: result must hold while in_valid toggles with fresh operands.
        div_if.Xin      = 16'h2000;
        div_if.Yin      = 16'h1000;
        div_if.in_valid = 1'b1;
        @(posedge clk); #1;
        div_if.in_valid = 1'b0;
        lat = 0;
        while (div_if.out_valid !== 1'b1 && lat < 4 * ITERS) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, ITERS);
        cz = div_if.Z0;
        cy = div_if.Y0;
        cd = div_if.dbz;
        co = div_if.ovf;
        chk_rng("bp_z0", sval(cz), 4094, 4098);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            div_if.in_valid = c[0];
            div_if.Xin      = 16'($urandom);
            div_if.Yin      = 16'($urandom);
            @(posedge clk); #1;
            if (div_if.out_valid !== 1'b1 || div_if.in_ready !== 1'b0 || div_if.Z0 !== cz ||
                div_if.Y0 !== cy || div_if.dbz !== cd || div_if.ovf !== co) bad++;
        end
        div_if.in_valid = 1'b0;
        chk("bp_hold_bad_cycles", bad, 0);
        div_if.out_ready = 1'b1;
        @(posedge clk); #1;
        div_if.out_ready = 1'b0;
        chk("bp_release_out_valid", int'(div_if.out_valid), 0);
        chk("bp_release_in_ready", int'(div_if.in_ready), 1);

        // Abort with reset at iteration 7 of a divide-by-zero operation.
        div_if.Xin      = 16'h0000;
        div_if.Yin      = 16'h1234;
        div_if.in_valid = 1'b1;
        @(posedge clk); #1;
        div_if.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_dbz_before", int'(div_if.dbz), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(div_if.out_valid), 0);
        chk("abort_z0", int'(div_if.Z0), 0);
        chk("abort_dbz", int'(div_if.dbz), 0);
        chk("abort_ovf", int'(div_if.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < ITERS + 6; c++) begin
            @(posedge clk); #1;
            if (div_if.out_valid !== 1'b0) bad++;
        end
        chk("abort_no_result", bad, 0);
        run_op(16'h4000, 16'h2000, 0, lat, z0, y0, fd, fo);
        chk("abort_next_latency", lat, ITERS);
        chk_rng("abort_next_z0", sval(z0), 4094, 4098);
        chk("abort_next_dbz", int'(fd), 0);

        // Random in-range-able divisors that shift without truncation.
        for (int n = 0; n < 150; n++) begin
            kk = int'($urandom_range(0, 6));
            kk = (kk < 4) ? kk - 4 : kk - 3;
            xv = 16'(kk * 8192);
            yv = 16'($urandom);
            sx = sval(xv);
            sy = sval(yv);
            run_op(xv, yv, int'($urandom_range(0, 3)), lat, z0, y0, fd, fo);
            chk("rnd_latency", lat, ITERS);
            chk("rnd_dbz", int'(fd), 0);
            chk("rnd_ovf", int'(fo), int'(ref_ovf(sx, sy)));
            if (!ref_ovf(sx, sy)) begin
                chk_rng("rnd_z0", sval(z0), ref_quot(sx, sy) - 2, ref_quot(sx, sy) + 2);
                chk("rnd_y0_residual", sval(y0) * 8192, sy * 8192 - sx * sval(z0));
            end
        end

        // Fully random operands: flags, latency and divide-by-zero outputs.
        for (int n = 0; n < 60; n++) begin
            xv = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            yv = 16'($urandom);
            sx = sval(xv);
            sy = sval(yv);
            run_op(xv, yv, int'($urandom_range(0, 2)), lat, z0, y0, fd, fo);
            chk("any_latency", lat, ITERS);
            chk("any_dbz", int'(fd), int'(sx == 0));
            chk("any_ovf", int'(fo), int'(ref_ovf(sx, sy)));
            if (sx == 0) begin
                chk("any_dbz_z0", sval(z0), (sy >= 0) ? 32767 : -32767);
                chk("any_dbz_y0", sval(y0), sy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
